nbit_comparator: RTL and testbench

Registered magnitude comparator for two WIDTH-bit operands. Produces one-hot less-than / greater-than / equal flags one clock after the operands are presented. Supports unsigned and two's-complement signed comparison. Used wherever datapath logic needs a clean, registered A-vs-B decision; the default build is 16 bits wide.

---
 rtl/nbit_comparator_if.sv | 15 +
 rtl/nbit_comparator.sv | 41 ++++
 tb/tb_nbit_comparator.sv | 107 ++++++++++
 3 files changed

// File: rtl/nbit_comparator_if.sv
// nbit_comparator_if: operand and result-flag bundle for nbit_comparator.
interface nbit_comparator_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic             signed_mode;
   logic             lt;
   logic             gt;
   logic             eq;
   logic             out_valid;
   modport master (output a, b, in_valid, signed_mode, input lt, gt, eq, out_valid);
   modport slave (input a, b, in_valid, signed_mode, output lt, gt, eq, out_valid);
endinterface

// File: rtl/nbit_comparator.sv
// nbit_comparator: registered unsigned / two's-complement magnitude comparator
// with one-hot lt/gt/eq flags, one cycle of latency.
module nbit_comparator #(
   parameter int WIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   nbit_comparator_if.slave cmp
);
   logic lt_q, gt_q, eq_q, out_valid_q;
   logic lt_d, gt_d, eq_d, out_valid_d;
   logic a_msb, b_msb, eq_c, lt_c;
   always_comb begin
      a_msb = cmp.a[WIDTH-1];
      b_msb = cmp.b[WIDTH-1];
      eq_c = cmp.a == cmp.b;
      // differing MSBs settle the order: set MSB is larger unsigned, smaller signed
      lt_c = (a_msb != b_msb) ? (cmp.signed_mode ? a_msb : b_msb) : (cmp.a < cmp.b);
      lt_d = cmp.in_valid ? lt_c : lt_q;
      gt_d = cmp.in_valid ? (!lt_c && !eq_c) : gt_q;
      eq_d = cmp.in_valid ? eq_c : eq_q;
      out_valid_d = cmp.in_valid;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         lt_q <= 1'b0;
         gt_q <= 1'b0;
         eq_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         lt_q <= lt_d;
         gt_q <= gt_d;
         eq_q <= eq_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign cmp.lt = lt_q;
   assign cmp.gt = gt_q;
   assign cmp.eq = eq_q;
   assign cmp.out_valid = out_valid_q;
endmodule

// File: tb/tb_nbit_comparator.sv
// tb_nbit_comparator: directed vector table, hand-written hold/reset sequences
// and a random sweep against a $signed-based reference model.
module tb_nbit_comparator;
   localparam int W = 16;
   typedef struct {
      string      name;
      logic       sm;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0] exp;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   vec_t vecs[$];
   nbit_comparator_if #(.WIDTH(W)) cmp_if ();
   nbit_comparator #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .cmp(cmp_if)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [3:0] exp);
      logic [3:0] got;
      got = {cmp_if.out_valid, cmp_if.lt, cmp_if.gt, cmp_if.eq};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {ov,lt,gt,eq}=%b expected %b", name, got, exp);
      end
   endtask
   task automatic drive(input logic r, input logic v, input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
      rst = r;
      cmp_if.in_valid = v;
      cmp_if.signed_mode = sm;
      cmp_if.a = a;
      cmp_if.b = b;
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [2:0] model;
      logic [W-1:0] ra, rb;
      logic rsm, rv, mlt, meq;
      vecs.push_back('{"u_0_1", 1'b0, 16'h0000, 16'h0001, 3'b100});
      vecs.push_back('{"u_ff00_ffff", 1'b0, 16'hff00, 16'hffff, 3'b100});
      vecs.push_back('{"u_1001_1001", 1'b0, 16'h1001, 16'h1001, 3'b001});
      vecs.push_back('{"u_b000_a019", 1'b0, 16'hb000, 16'ha019, 3'b010});
      vecs.push_back('{"s_8000_0001", 1'b1, 16'h8000, 16'h0001, 3'b100});
      vecs.push_back('{"u_8000_0001", 1'b0, 16'h8000, 16'h0001, 3'b010});
      vecs.push_back('{"s_ffff_0000", 1'b1, 16'hffff, 16'h0000, 3'b100});
      vecs.push_back('{"u_ffff_0000", 1'b0, 16'hffff, 16'h0000, 3'b010});
      vecs.push_back('{"s_b000_a019", 1'b1, 16'hb000, 16'ha019, 3'b010});
      vecs.push_back('{"u_zero_zero", 1'b0, 16'h0000, 16'h0000, 3'b001});
      vecs.push_back('{"s_ones_ones", 1'b1, 16'hffff, 16'hffff, 3'b001});
      vecs.push_back('{"u_ones_ones", 1'b0, 16'hffff, 16'hffff, 3'b001});
      vecs.push_back('{"u_8000_7fff", 1'b0, 16'h8000, 16'h7fff, 3'b010});
      vecs.push_back('{"s_8000_7fff", 1'b1, 16'h8000, 16'h7fff, 3'b100});
      vecs.push_back('{"s_7fff_8000", 1'b1, 16'h7fff, 16'h8000, 3'b010});
      vecs.push_back('{"s_fffe_ffff", 1'b1, 16'hfffe, 16'hffff, 3'b100});
      // reset overrides a pending valid operand pair
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000);
         check("reset_hold", 4'b0000);
      end
      foreach (vecs[i]) begin
         drive(1'b0, 1'b1, vecs[i].sm, vecs[i].a, vecs[i].b);
         check(vecs[i].name, {1'b1, vecs[i].exp});
      end
      drive(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0003);
      check("hold_accept", 4'b1010);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 16'(i), 16'hffff - 16'(i));
         check("hold_idle", 4'b0010);
      end
      drive(1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234);
      check("mid_accept", 4'b1001);
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'hffff);
      check("mid_reset", 4'b0000);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'hffff);
      check("post_reset", 4'b1100);
      model = 3'b100;
      for (int i = 0; i < 10000; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         rsm = 1'($urandom_range(0, 1));
         rv = $urandom_range(0, 9) != 0;
         drive(1'b0, rv, rsm, ra, rb);
         if (rv) begin
            meq = ra == rb;
            mlt = rsm ? ($signed(ra) < $signed(rb)) : (ra < rb);
            model = {mlt, !mlt && !meq, meq};
         end
         check("random", {rv, model});
         if (rv) begin
            checks++;
            if (!$onehot({cmp_if.lt, cmp_if.gt, cmp_if.eq})) begin
               errors++;
               $display("FAIL onehot: got {lt,gt,eq}=%b required exactly one set", {cmp_if.lt, cmp_if.gt, cmp_if.eq});
            end
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
